// File: rtl/product_accumulator.sv
// Frame accumulator: sums frame_len unsigned product words, then holds the result for a handshake.
// Build option: define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp the accumulator instead of wrapping.
module product_accumulator #(
   parameter int bit_width = 8,
   parameter int acc_width = 10,
   parameter int frame_len = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 prod_valid,
   output logic                 prod_ready,
   input  logic [bit_width-1:0] prod,
   output logic                 sum_valid,
   input  logic                 sum_ready,
   output logic [acc_width-1:0] sum,
   output logic                 ovf
);

   localparam int cnt_w = (frame_len > 1) ? $clog2(frame_len) : 1;
   localparam logic [cnt_w-1:0] last_beat = cnt_w'(frame_len - 1);

   typedef enum logic {ACC, HOLD} state_t;

   state_t               state;
   logic [acc_width-1:0] acc;
   logic [cnt_w-1:0]     cnt;
   logic                 ovf_flag;
   logic [acc_width:0]   add_p0;

   // Returns {carry, result}; the carry is always the raw carry so ovf reporting is build-independent.
   function automatic logic [acc_width:0] sat_add(input logic [acc_width-1:0] a,
                                                   input logic [bit_width-1:0] p);
      logic [acc_width:0] w;
      w = {1'b0, a} + (acc_width + 1)'(p);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
      if (w[acc_width]) w[acc_width-1:0] = '1;
`endif
      return w;
   endfunction

   assign add_p0     = sat_add(acc, prod);
   assign prod_ready = rst_n && (state == ACC);

   // Stage p0 -> registered frame result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACC;
         acc       <= '0;
         cnt       <= '0;
         ovf_flag  <= 1'b0;
         sum       <= '0;
         ovf       <= 1'b0;
         sum_valid <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (prod_valid) begin
                  acc      <= add_p0[acc_width-1:0];
                  ovf_flag <= ovf_flag | add_p0[acc_width];
                  if (cnt == last_beat) begin
                     state     <= HOLD;
                     sum       <= add_p0[acc_width-1:0];
                     ovf       <= ovf_flag | add_p0[acc_width];
                     sum_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (sum_ready) begin
                  state     <= ACC;
                  acc       <= '0;
                  cnt       <= '0;
                  ovf_flag  <= 1'b0;
                  sum_valid <= 1'b0;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule
